// File: rtl/carregador_programa.sv
// Program loader: fills instruction memory from a byte stream carrying a 16-bit
// word-count header followed by big-endian 32-bit words.
module carregador_programa #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int ENDERECO_BASE  = 0,
    parameter int TIMEOUT_CICLOS = 1000000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Iniciar,
    input  logic                  Byte_Valido,
    input  logic [7:0]            Byte_Dado,
    output logic [ADDR_WIDTH-1:0] Endereco,
    output logic [DATA_WIDTH-1:0] Dado,
    output logic                  Write_Enable,
    output logic                  Ocupado,
    output logic                  Concluido,
    output logic                  Erro
);
    // The idle counter never needs to hold more than TIMEOUT_CICLOS-1.
    localparam int TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ENDERECO_BASE);
    localparam logic [32:0] CAPACIDADE = 33'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {OCIOSO, CAB_ALTO, CAB_BAIXO, DADOS, FIM} estado_t;

    estado_t               estado_reg, estado_next;
    logic [ADDR_WIDTH-1:0] endereco_reg, endereco_next;
    logic [DATA_WIDTH-1:0] dado_reg, dado_next;
    logic [DATA_WIDTH-1:0] palavra_reg, palavra_next;
    logic                  write_enable_reg, write_enable_next;
    logic                  concluido_reg, concluido_next;
    logic                  erro_reg, erro_next;
    logic [1:0]            indice_reg, indice_next;
    logic [TW-1:0]         timer_reg, timer_next;
    logic [15:0]           restante_reg, restante_next;
    logic [7:0]            cab_alto_reg, cab_alto_next;
    logic [15:0]           contagem;
    logic                  expira, ativo, aceita_dado;

    assign ativo       = (estado_reg == CAB_ALTO) || (estado_reg == CAB_BAIXO) || (estado_reg == DADOS);
    assign aceita_dado = Byte_Valido && (estado_reg == DADOS);
    assign expira      = (timer_reg == TW'(TIMEOUT_CICLOS - 1));
    assign contagem    = {cab_alto_reg, Byte_Dado};

    // Byte lane gi of the word under assembly takes the incoming byte when the index points at it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign palavra_next[DATA_WIDTH-1-8*gi -: 8] =
                (aceita_dado && indice_reg == 2'(gi)) ? Byte_Dado
                                                      : palavra_reg[DATA_WIDTH-1-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) estado_reg <= OCIOSO;
        else       estado_reg <= estado_next;
    end

    always_comb begin
        estado_next       = estado_reg;
        endereco_next     = write_enable_reg ? endereco_reg + ADDR_WIDTH'(1) : endereco_reg;
        dado_next         = dado_reg;
        write_enable_next = 1'b0;
        concluido_next    = 1'b0;
        erro_next         = erro_reg;
        indice_next       = indice_reg;
        timer_next        = timer_reg;
        restante_next     = restante_reg;
        cab_alto_next     = cab_alto_reg;

        // A byte arriving on the expiry cycle takes precedence over the timeout.
        if (ativo) begin
            if (Byte_Valido) begin
                timer_next = '0;
            end else if (expira) begin
                timer_next  = '0;
                erro_next   = 1'b1;
                estado_next = OCIOSO;
            end else begin
                timer_next = timer_reg + TW'(1);
            end
        end

        case (estado_reg)
            OCIOSO: begin
                if (Iniciar) begin
                    estado_next   = CAB_ALTO;
                    erro_next     = 1'b0;
                    endereco_next = BASE;
                    indice_next   = 2'd0;
                    timer_next    = '0;
                end
            end
            CAB_ALTO: begin
                if (Byte_Valido) begin
                    cab_alto_next = Byte_Dado;
                    estado_next   = CAB_BAIXO;
                end
            end
            CAB_BAIXO: begin
                if (Byte_Valido) begin
                    if (contagem == 16'd0) begin
                        estado_next = FIM;
                    end else if (33'(contagem) > CAPACIDADE) begin
                        erro_next   = 1'b1;
                        estado_next = OCIOSO;
                    end else begin
                        restante_next = contagem;
                        estado_next   = DADOS;
                    end
                end
            end
            DADOS: begin
                if (Byte_Valido) begin
                    indice_next = indice_reg + 2'd1;
                    if (indice_reg == 2'd3) begin
                        dado_next         = palavra_next;
                        write_enable_next = 1'b1;
                        restante_next     = restante_reg - 16'd1;
                        if (restante_reg == 16'd1) estado_next = FIM;
                    end
                end
            end
            FIM: begin
                estado_next    = OCIOSO;
                concluido_next = 1'b1;
            end
            default: estado_next = OCIOSO;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            endereco_reg     <= BASE;
            dado_reg         <= '0;
            palavra_reg      <= '0;
            write_enable_reg <= 1'b0;
            concluido_reg    <= 1'b0;
            erro_reg         <= 1'b0;
            indice_reg       <= 2'd0;
            timer_reg        <= '0;
            restante_reg     <= 16'd0;
            cab_alto_reg     <= 8'd0;
        end else begin
            endereco_reg     <= endereco_next;
            dado_reg         <= dado_next;
            palavra_reg      <= palavra_next;
            write_enable_reg <= write_enable_next;
            concluido_reg    <= concluido_next;
            erro_reg         <= erro_next;
            indice_reg       <= indice_next;
            timer_reg        <= timer_next;
            restante_reg     <= restante_next;
            cab_alto_reg     <= cab_alto_next;
        end
    end

    assign Endereco     = endereco_reg;
    assign Dado         = dado_reg;
    assign Write_Enable = write_enable_reg;
    assign Ocupado      = (estado_reg != OCIOSO);
    assign Concluido    = concluido_reg;
    assign Erro         = erro_reg;
endmodule

// File: tb/tb_carregador_programa.sv
// Bench for carregador_programa: two instances (base 0 and base 1023) fed the same
// stream, compared every cycle against a transaction-level model of the loader.
module tb_carregador_programa;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ini = 1'b0;
    logic       bv  = 1'b0;
    logic [7:0] b   = 8'd0;

    logic [9:0]  end_a, end_b;
    logic [31:0] dado_a, dado_b;
    logic        we_a, we_b, oc_a, oc_b, co_a, co_b, er_a, er_b;

    always #5 clk = ~clk;

    carregador_programa #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ENDERECO_BASE(0), .TIMEOUT_CICLOS(T)) dut_a (
        .Clock(clk), .Reset(rst), .Iniciar(ini), .Byte_Valido(bv), .Byte_Dado(b),
        .Endereco(end_a), .Dado(dado_a), .Write_Enable(we_a), .Ocupado(oc_a),
        .Concluido(co_a), .Erro(er_a));

    carregador_programa #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ENDERECO_BASE(1023), .TIMEOUT_CICLOS(T)) dut_b (
        .Clock(clk), .Reset(rst), .Iniciar(ini), .Byte_Valido(bv), .Byte_Dado(b),
        .Endereco(end_b), .Dado(dado_b), .Write_Enable(we_b), .Ocupado(oc_b),
        .Concluido(co_b), .Erro(er_b));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: which phase of a load we are in, counted in bytes and words.
    bit          m_ativo, m_fim, e_we, e_conc, e_erro;
    int          m_hdr, m_count, m_bytes, m_idle, m_off, m_widx;
    logic [31:0] e_dado;
    logic [7:0]  q[$];

    task automatic model_reset();
        m_ativo = 0; m_fim = 0; e_we = 0; e_conc = 0; e_erro = 0;
        m_hdr = 0; m_count = 0; m_bytes = 0; m_idle = 0; m_off = 0; m_widx = 0;
        e_dado = '0;
        q.delete();
    endtask

    task automatic model_step();
        bit was_we;
        was_we = e_we;
        e_we   = 0;
        e_conc = 0;
        if (was_we) m_off++;
        if (m_fim) begin
            m_fim  = 0;
            e_conc = 1;
        end else if (!m_ativo) begin
            if (ini) begin
                m_ativo = 1; m_hdr = 0; m_count = 0; m_bytes = 0; m_idle = 0;
                e_erro = 0; m_off = 0;
                q.delete();
            end
        end else if (bv) begin
            m_idle = 0;
            if (m_hdr < 2) begin
                m_count = m_count * 256 + int'(b);
                m_hdr++;
                if (m_hdr == 2) begin
                    if (m_count == 0) begin
                        m_ativo = 0; m_fim = 1;
                    end else if (m_count > 1024) begin
                        m_ativo = 0; e_erro = 1;
                    end
                end
            end else begin
                q.push_back(b);
                m_bytes++;
                if (m_bytes % 4 == 0) begin
                    e_we   = 1;
                    e_dado = {q[m_bytes-4], q[m_bytes-3], q[m_bytes-2], q[m_bytes-1]};
                    m_widx = m_bytes / 4 - 1;
                    if (m_bytes / 4 == m_count) begin
                        m_ativo = 0; m_fim = 1;
                    end
                end
            end
        end else begin
            m_idle++;
            if (m_idle == T) begin
                m_ativo = 0; e_erro = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    int nw_a = 0;
    int nw_b = 0;

    // Per-cycle comparison, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("we_a", 32'(we_a), 32'(e_we));
            chk("we_b", 32'(we_b), 32'(e_we));
            chk("ocupado_a", 32'(oc_a), 32'(m_ativo || m_fim));
            chk("ocupado_b", 32'(oc_b), 32'(m_ativo || m_fim));
            chk("concluido_a", 32'(co_a), 32'(e_conc));
            chk("concluido_b", 32'(co_b), 32'(e_conc));
            chk("erro_a", 32'(er_a), 32'(e_erro));
            chk("erro_b", 32'(er_b), 32'(e_erro));
            chk("endereco_a", 32'(end_a), 32'(m_off % 1024));
            chk("endereco_b", 32'(end_b), 32'((1023 + m_off) % 1024));
            if (e_we) begin
                chk("dado_a", dado_a, e_dado);
                chk("dado_b", dado_b, e_dado);
                chk("waddr_a", 32'(end_a), 32'(m_widx % 1024));
                chk("waddr_b", 32'(end_b), 32'((1023 + m_widx) % 1024));
            end
            if (we_a === 1'b1) begin
                mem_a[end_a] = dado_a;
                nw_a++;
                $display("[TB] write %h @%0d (base 0), %h @%0d (base 1023)", dado_a, end_a, dado_b, end_b);
            end
            if (we_b === 1'b1) begin
                mem_b[end_b] = dado_b;
                nw_b++;
            end
        end
    end

    task automatic pulse(input bit i, input bit v, input logic [7:0] d);
        ini = i; bv = v; b = d;
        @(posedge clk);
        #2;
        ini = 1'b0; bv = 1'b0; b = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) pulse(1'b0, 1'b0, 8'd0);
    endtask

    task automatic send(input logic [7:0] d);
        pulse(1'b0, 1'b1, d);
    endtask

    logic [7:0] normal [10];
    int w0;

    initial begin
        normal = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_dado", dado_a, 32'h0);
        chk("reset_endereco_a", 32'(end_a), 32'd0);
        chk("reset_endereco_b", 32'(end_b), 32'd1023);
        chk("reset_ocupado", 32'(oc_a), 32'd0);

        // Normal two-word load, also exercising the 1023 -> 0 wrap on dut_b.
        $display("[TB] load normal");
        pulse(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) send(normal[i]);
        chk("normal_we", 32'(we_a), 32'd1);
        chk("normal_dado", dado_a, 32'h9ABCDEF0);
        chk("normal_addr_b", 32'(end_b), 32'd0);
        chk("normal_fim_ocupado", 32'(oc_a), 32'd1);
        idle(1);
        chk("normal_concluido", 32'(co_a), 32'd1);
        chk("normal_ocupado", 32'(oc_a), 32'd0);
        chk("normal_erro", 32'(er_a), 32'd0);
        chk("normal_mem0", mem_a[0], 32'h12345678);
        chk("normal_mem1", mem_a[1], 32'h9ABCDEF0);
        chk("wrap_mem1023", mem_b[1023], 32'h12345678);
        chk("wrap_mem0", mem_b[0], 32'h9ABCDEF0);
        chk("normal_nwrites", 32'(nw_a), 32'd2);
        idle(2);

        $display("[TB] load empty");
        w0 = nw_a;
        pulse(1'b1, 1'b0, 8'd0);
        send(8'h00); send(8'h00);
        chk("empty_fim", 32'(oc_a), 32'd1);
        idle(1);
        chk("empty_concluido", 32'(co_a), 32'd1);
        chk("empty_ocupado", 32'(oc_a), 32'd0);
        chk("empty_nwrites", 32'(nw_a), 32'(w0));
        idle(2);

        $display("[TB] load oversize");
        pulse(1'b1, 1'b0, 8'd0);
        send(8'h04); send(8'h01);
        chk("oversize_erro", 32'(er_a), 32'd1);
        chk("oversize_ocupado", 32'(oc_a), 32'd0);
        idle(2);
        pulse(1'b1, 1'b0, 8'd0);
        chk("restart_clears_erro", 32'(er_a), 32'd0);
        send(8'h00); send(8'h00);
        idle(2);
        chk("oversize_nwrites", 32'(nw_a), 32'(w0));

        $display("[TB] load byte at expiry");
        pulse(1'b1, 1'b0, 8'd0);
        send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
        idle(T - 1);
        send(8'hCC);
        chk("expiry_byte_ocupado", 32'(oc_a), 32'd1);
        chk("expiry_byte_erro", 32'(er_a), 32'd0);
        send(8'hDD);
        chk("expiry_byte_dado", dado_a, 32'hAABBCCDD);
        idle(2);

        $display("[TB] load timeout");
        w0 = nw_a;
        pulse(1'b1, 1'b0, 8'd0);
        send(8'h00); send(8'h01); send(8'h11); send(8'h22);
        idle(T - 1);
        chk("timeout_pre_ocupado", 32'(oc_a), 32'd1);
        idle(1);
        chk("timeout_erro", 32'(er_a), 32'd1);
        chk("timeout_ocupado", 32'(oc_a), 32'd0);
        idle(2);
        chk("timeout_nwrites", 32'(nw_a), 32'(w0));

        $display("[TB] load reset mid-word");
        pulse(1'b1, 1'b0, 8'd0);
        send(8'h00); send(8'h01); send(8'h55); send(8'h66); send(8'h77);
        #1 rst = 1'b1;
        #1;
        chk("rst_ocupado", 32'(oc_a), 32'd0);
        chk("rst_dado", dado_a, 32'h0);
        chk("rst_endereco_b", 32'(end_b), 32'd1023);
        chk("rst_erro", 32'(er_a), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(2);
        chk("rst_nwrites", 32'(nw_a), 32'(w0));

        $display("[TB] load back-to-back with Iniciar noise");
        w0 = nw_a;
        pulse(1'b1, 1'b0, 8'd0);
        pulse(1'b1, 1'b1, 8'h00);
        pulse(1'b1, 1'b1, 8'h03);
        for (int i = 1; i <= 12; i++) pulse(1'b1, 1'b1, 8'(i));
        idle(2);
        chk("b2b_mem0", mem_a[0], 32'h01020304);
        chk("b2b_mem1", mem_a[1], 32'h05060708);
        chk("b2b_mem2", mem_a[2], 32'h090A0B0C);
        chk("b2b_nwrites", 32'(nw_a - w0), 32'd3);

        for (int k = 0; k < 30; k++) begin
            int r, cnt, nbytes, g;
            logic [15:0] c16;
            r = int'($urandom_range(0, 9));
            if (r < 7)      cnt = int'($urandom_range(0, 5));
            else if (r < 9) cnt = 1025 + int'($urandom_range(0, 2000));
            else            cnt = int'($urandom_range(6, 12));
            $display("[TB] load random %0d: count %0d", k, cnt);
            c16 = 16'(cnt);
            nbytes = (cnt > 1024) ? 2 : 2 + 4 * cnt;
            pulse(1'b1, 1'b0, 8'd0);
            for (int j = 0; j < nbytes; j++) begin
                g = ($urandom_range(0, 39) == 0) ? int'($urandom_range(T - 2, T + 2))
                                                 : int'($urandom_range(0, 2));
                repeat (g) pulse($urandom_range(0, 7) == 0, 1'b0, 8'd0);
                if (j == 0)      pulse($urandom_range(0, 9) == 0, 1'b1, c16[15:8]);
                else if (j == 1) pulse($urandom_range(0, 9) == 0, 1'b1, c16[7:0]);
                else             pulse($urandom_range(0, 9) == 0, 1'b1, 8'($urandom));
            end
            repeat (3) pulse(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        idle(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
